// File: rtl/injection_table_port_arbiter.sv
// Slot-table RAM port arbiter: clears the table after reset, then shares
// the port between scheduler lookups (priority) and host config access.
module injection_table_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            iv_cfg_finish,
    input  logic                  i_cfg_wr,
    input  logic                  i_cfg_rd,
    input  logic [ADDR_WIDTH-1:0] iv_cfg_addr,
    input  logic [DATA_WIDTH-1:0] iv_cfg_wdata,
    output logic [DATA_WIDTH-1:0] ov_cfg_rdata,
    output logic                  o_cfg_rdata_valid,
    output logic                  o_cfg_busy,
    output logic [7:0]            ov_cfg_drop_cnt,
    input  logic                  i_time_slot_switch,
    input  logic [ADDR_WIDTH-1:0] iv_time_slot,
    output logic [DATA_WIDTH-1:0] ov_slot_entry,
    output logic                  o_slot_entry_valid,
    output logic [ADDR_WIDTH-1:0] ov_ram_addr,
    output logic [DATA_WIDTH-1:0] ov_ram_wdata,
    output logic                  o_ram_wr,
    output logic                  o_ram_rd,
    input  logic [DATA_WIDTH-1:0] iv_ram_rdata,
    output logic [1:0]            ov_arb_state
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_RUN  = 2'b01
    } state_t;

    state_t                state, state_nx;
    logic [CNT_W-1:0]      init_cnt, init_cnt_nx;

    logic                  hold_valid, hold_valid_nx;
    logic                  hold_wr, hold_wr_nx;
    logic [ADDR_WIDTH-1:0] hold_addr, hold_addr_nx;
    logic [DATA_WIDTH-1:0] hold_wdata, hold_wdata_nx;
    logic [7:0]            drop_cnt, drop_cnt_nx;

    logic                  cmd_wr_nx, cmd_rd_nx;
    logic [ADDR_WIDTH-1:0] cmd_addr_nx;
    logic [DATA_WIDTH-1:0] cmd_wdata_nx;

    // tag = {valid read, is lookup}; tag1 lines up with iv_ram_rdata
    logic [1:0]            tag_nx, tag0, tag1;

    logic                  lk_req, cfg_req, load, drop;

    assign lk_req  = i_time_slot_switch && (iv_cfg_finish == 2'b11);
    assign cfg_req = i_cfg_wr || i_cfg_rd;

    assign o_cfg_busy      = hold_valid;
    assign ov_cfg_drop_cnt = drop_cnt;
    assign ov_arb_state    = state;

    // Next-state, grant selection and holding-register decisions
    always_comb begin
        state_nx      = state;
        init_cnt_nx   = init_cnt;
        hold_valid_nx = hold_valid;
        hold_wr_nx    = hold_wr;
        hold_addr_nx  = hold_addr;
        hold_wdata_nx = hold_wdata;
        drop_cnt_nx   = drop_cnt;
        cmd_wr_nx     = 1'b0;
        cmd_rd_nx     = 1'b0;
        cmd_addr_nx   = '0;
        cmd_wdata_nx  = '0;
        tag_nx        = 2'b00;
        load          = 1'b0;
        drop          = 1'b0;

        unique case (state)
            ST_INIT: begin
                if (init_cnt == DEPTH) begin
                    state_nx = ST_RUN;
                end else begin
                    cmd_wr_nx   = 1'b1;
                    cmd_addr_nx = init_cnt[ADDR_WIDTH-1:0];
                    init_cnt_nx = init_cnt + CNT_W'(1);
                end
                if (cfg_req) begin
                    load = !hold_valid;
                    drop = hold_valid;
                end
            end
            ST_RUN: begin
                if (lk_req) begin
                    cmd_rd_nx   = 1'b1;
                    cmd_addr_nx = iv_time_slot;
                    tag_nx      = 2'b11;
                    if (cfg_req) begin
                        load = !hold_valid;
                        drop = hold_valid;
                    end
                end else if (hold_valid) begin
                    cmd_wr_nx     = hold_wr;
                    cmd_rd_nx     = !hold_wr;
                    cmd_addr_nx   = hold_addr;
                    cmd_wdata_nx  = hold_wr ? hold_wdata : '0;
                    tag_nx        = {!hold_wr, 1'b0};
                    hold_valid_nx = 1'b0;
                    load          = cfg_req;
                end else if (cfg_req) begin
                    cmd_wr_nx    = i_cfg_wr;
                    cmd_rd_nx    = !i_cfg_wr;
                    cmd_addr_nx  = iv_cfg_addr;
                    cmd_wdata_nx = i_cfg_wr ? iv_cfg_wdata : '0;
                    tag_nx       = {!i_cfg_wr, 1'b0};
                end
            end
            default: state_nx = ST_INIT;
        endcase

        if (load) begin
            hold_valid_nx = 1'b1;
            hold_wr_nx    = i_cfg_wr;
            hold_addr_nx  = iv_cfg_addr;
            hold_wdata_nx = iv_cfg_wdata;
        end
        if (drop && drop_cnt != 8'hFF) begin
            drop_cnt_nx = drop_cnt + 8'd1;
        end
    end

    // FSM state and clear-address counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nx;
            init_cnt <= init_cnt_nx;
        end
    end

    // Holding register and drop counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_valid <= 1'b0;
            hold_wr    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            drop_cnt   <= '0;
        end else begin
            hold_valid <= hold_valid_nx;
            hold_wr    <= hold_wr_nx;
            hold_addr  <= hold_addr_nx;
            hold_wdata <= hold_wdata_nx;
            drop_cnt   <= drop_cnt_nx;
        end
    end

    // Registered RAM command and read-tag pipe
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ram_wr     <= 1'b0;
            o_ram_rd     <= 1'b0;
            ov_ram_addr  <= '0;
            ov_ram_wdata <= '0;
            tag0         <= 2'b00;
            tag1         <= 2'b00;
        end else begin
            o_ram_wr     <= cmd_wr_nx;
            o_ram_rd     <= cmd_rd_nx;
            ov_ram_addr  <= cmd_addr_nx;
            ov_ram_wdata <= cmd_wdata_nx;
            tag0         <= tag_nx;
            tag1         <= tag0;
        end
    end

    // Steer returning read data to the lookup or config response
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ov_slot_entry      <= '0;
            o_slot_entry_valid <= 1'b0;
            ov_cfg_rdata       <= '0;
            o_cfg_rdata_valid  <= 1'b0;
        end else begin
            o_slot_entry_valid <= tag1[1] && tag1[0];
            o_cfg_rdata_valid  <= tag1[1] && !tag1[0];
            if (tag1[1] && tag1[0]) begin
                ov_slot_entry <= iv_ram_rdata;
            end
            if (tag1[1] && !tag1[0]) begin
                ov_cfg_rdata <= iv_ram_rdata;
            end
        end
    end

endmodule
